video_timing_monitor: RTL and testbench
=======================================

// Module: video_timing_monitor
// PURPOSE
// - Sink-side counterpart of the core's video timing generator. Consumes the rgb/enable/vsync/hsync stream on pixel_clock.
// - Rebuilds per-pixel coordinates and measures line/frame geometry.
// - Locks once geometry is stable and produces a per-frame checksum of active pixels.
// - Sits on the video bus for on-chip self-check and debug readout. Drives nothing back to the source.
// PARAMETERS
// - COORD_WIDTH    12    width of coordinate and measurement counters; counters saturate at all-ones
// - MAX_LINES      2047  hsync count without a vsync after which the monitor drops to SEARCH
// PORTS
// - pixel_clock     in   1            pixel clock; all logic on its rising edge
// - reset_n         in   1            asynchronous, active-low reset
// - video_rgb       in   24           pixel {R,G,B}, meaningful only when video_enable=1
// - video_enable    in   1            active-pixel qualifier
// - video_vsync     in   1            one-cycle frame-start pulse, active high
// - video_hsync     in   1            one-cycle line-start pulse, active high
// - pixel_x         out  COORD_WIDTH  column of current active pixel
// - pixel_y         out  COORD_WIDTH  row of current active pixel
// - pixel_rgb       out  24           registered copy of video_rgb
// - pixel_valid     out  1            pixel_x/pixel_y/pixel_rgb valid this cycle
// - h_total         out  COORD_WIDTH  clocks between consecutive hsync pulses (latched)
// - v_total         out  COORD_WIDTH  hsync pulses per frame (latched)
// - h_active        out  COORD_WIDTH  enable cycles in first active line (latched)
// - v_active        out  COORD_WIDTH  lines containing at least one enable cycle (latched)
// - frame_checksum  out  32           checksum of the last completed frame
// - checksum_valid  out  1            one-cycle pulse when frame_checksum updates
// - locked          out  1            geometry stable
// - timing_error    out  1            one-cycle pulse on geometry mismatch while LOCKED
// BEHAVIOUR
// - Reset: all outputs 0. State SEARCH. All counters and accumulators 0. Takes effect immediately, including mid-frame.
// - Pixel path: 1-cycle latency.
//   - pixel_valid(t+1)=video_enable(t). pixel_rgb(t+1)=video_rgb(t).
//   - pixel_x = 0 on first enable of a line, +1 per enable cycle. Enable gaps within a line do not reset it.
//   - pixel_y = 0 on first active line of a frame, +1 on each later line that contains enable.
// - Running counters, cleared on vsync:
//   - clk_in_line: cleared on hsync.
//   - line_cnt: +1 per hsync.
//   - act_lines: +1 per line with enable.
//   - first_h_act: enable count of the first active line.
//   - mismatch: set if any active line's enable count != first_h_act, or if clk_in_line at hsync != the previous line's.
// - Frame end = vsync. Candidate geometry = {clk_in_line at last hsync, line_cnt, first_h_act, act_lines}.
// - State machine:
//   - SEARCH: vsync -> MEASURE.
//   - MEASURE: vsync -> latch candidate into h_total/v_total/h_active/v_active -> VERIFY.
//   - VERIFY: vsync and candidate == latched and !mismatch -> LOCKED, locked=1. Otherwise relatch and stay in VERIFY.
//   - LOCKED: vsync with match -> stay. Mismatch -> timing_error pulse, locked=0, relatch -> VERIFY.
//   - Any state: line_cnt reaches MAX_LINES without vsync -> SEARCH, locked=0, latched values kept.
// - Checksum:
//   - acc <= rotl1(acc) ^ {8'h00, video_rgb} on each enable cycle.
//   - On vsync: frame_checksum <= acc, checksum_valid=1 (not in SEARCH), acc <= 0.
//   - Partial frame after reset/SEARCH produces no checksum_valid.
// - Simultaneous events:
//   - vsync and hsync in the same cycle: vsync closes the frame first, then hsync counts as line 1 of the new frame.
//   - enable in a vsync cycle: that pixel belongs to the new frame.
//   - enable in an hsync cycle: that pixel belongs to the new line.
// - Arithmetic:
//   - All counters unsigned, COORD_WIDTH, saturating. Saturation forces mismatch.
//   - Checksum wraps modulo 2^32.
// STRUCTURE
// - video_pkg:
//   - typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} mon_state_t
//   - typedef struct for {h_total, v_total, h_active, v_active}
//   - default COORD_WIDTH constant
// - Sub-module video_checksum: 32-bit rotate-xor accumulator with clear/enable/capture, shared with future capture blocks.
// TESTING
// - Generator 900x820 total, 800x720 active -> locked rises at 3rd vsync; h_total=900, v_total=820, h_active=800, v_active=720.
// - 2x2 active frame, all rgb=24'h000001 -> frame_checksum=32'h0000000F with one checksum_valid pulse per vsync.
// - First active pixel after reset -> pixel_valid one cycle after enable, pixel_x=0, pixel_y=0. Last pixel -> pixel_x=799, pixel_y=719.
// - While locked, one line stretched to 901 clocks -> timing_error 1-cycle pulse at next vsync, locked=0, relock after 1 clean frame.
// - hsync without vsync for 2047 lines -> state SEARCH, locked=0. Next two vsyncs -> MEASURE, then VERIFY.
// - reset_n low mid-frame for 1 cycle -> all outputs 0 immediately; no checksum_valid until the second vsync after release.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the video timing monitor and other sink-side video blocks.
package video_pkg;

    localparam int COORD_WIDTH_DEF = 12;

    typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} mon_state_t;

    // Line/frame geometry, held at the default coordinate width.
    typedef struct packed {
        logic [COORD_WIDTH_DEF-1:0] h_total;
        logic [COORD_WIDTH_DEF-1:0] v_total;
        logic [COORD_WIDTH_DEF-1:0] h_active;
        logic [COORD_WIDTH_DEF-1:0] v_active;
    } geom_t;

endpackage

// File: rtl/video_checksum.sv
// Rotate-xor accumulator over 24-bit pixels with frame clear and result capture.
module video_checksum (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [23:0] data,
    input  logic        capture,
    output logic [31:0] checksum
);

    logic [31:0] acc;
    logic [31:0] base;

    // Clear applies before the same-cycle pixel, so that pixel opens the new frame.
    always_comb base = clear ? '0 : acc;

    // Fold enabled pixels into the accumulator; capture samples the pre-clear value.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            checksum <= '0;
        end else begin
            acc <= enable ? ({base[30:0], base[31]} ^ {8'h00, data}) : base;
            if (capture) checksum <= acc;
        end
    end

endmodule

// File: rtl/video_timing_monitor.sv
// Sink-side timing monitor: pixel coordinates, geometry measurement, lock and frame checksum.
module video_timing_monitor
    import video_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int MAX_LINES   = 2047
) (
    input  logic                   pixel_clock,
    input  logic                   reset_n,
    input  logic [23:0]            video_rgb,
    input  logic                   video_enable,
    input  logic                   video_vsync,
    input  logic                   video_hsync,
    output logic [COORD_WIDTH-1:0] pixel_x,
    output logic [COORD_WIDTH-1:0] pixel_y,
    output logic [23:0]            pixel_rgb,
    output logic                   pixel_valid,
    output logic [COORD_WIDTH-1:0] h_total,
    output logic [COORD_WIDTH-1:0] v_total,
    output logic [COORD_WIDTH-1:0] h_active,
    output logic [COORD_WIDTH-1:0] v_active,
    output logic [31:0]            frame_checksum,
    output logic                   checksum_valid,
    output logic                   locked,
    output logic                   timing_error
);

    localparam logic [COORD_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [COORD_WIDTH-1:0] CNT_ONE    = COORD_WIDTH'(1);
    localparam logic [COORD_WIDTH-1:0] LINE_LIMIT = COORD_WIDTH'(MAX_LINES - 1);

    mon_state_t state, state_nxt;
    geom_t      geom_q, cand;

    logic [COORD_WIDTH-1:0] clk_in_line, line_cnt, act_lines, line_en_cnt;
    logic [COORD_WIDTH-1:0] first_h_act, last_clk, prev_clk;
    logic                   line_has_en, first_done, clk_ok, prev_ok, mismatch;

    logic                   line_start, close_active, act_len_bad, meas, clk_bad;
    logic                   frame_bad, ovf, has_base, latch, err, capture;
    logic                   sat_clk, sat_line, sat_en, sat_act, sat_now;
    logic [COORD_WIDTH-1:0] en_base, act_base, clk_nxt, line_nxt, en_nxt, act_nxt, h_act_cand;

    // Boundary decode and saturating next values; the line closing this cycle is judged before clearing.
    always_comb begin
        line_start   = video_vsync | video_hsync;
        close_active = line_start & line_has_en;
        act_len_bad  = close_active & first_done & (line_en_cnt != first_h_act);
        meas         = video_hsync & ~video_vsync & clk_ok;
        clk_bad      = meas & prev_ok & (clk_in_line != prev_clk);
        frame_bad    = mismatch | act_len_bad;
        ovf          = video_hsync & ~video_vsync & (line_cnt == LINE_LIMIT);

        en_base  = line_start ? '0 : line_en_cnt;
        act_base = video_vsync ? '0 : act_lines;
        has_base = ~line_start & line_has_en;

        sat_clk  = ~line_start & (clk_in_line == CNT_MAX);
        sat_line = video_hsync & ~video_vsync & (line_cnt == CNT_MAX);
        sat_en   = video_enable & (en_base == CNT_MAX);
        sat_act  = video_enable & ~has_base & (act_base == CNT_MAX);
        sat_now  = sat_clk | sat_line | sat_en | sat_act;

        clk_nxt  = line_start ? CNT_ONE : (sat_clk ? clk_in_line : clk_in_line + CNT_ONE);
        if (video_vsync)
            line_nxt = video_hsync ? CNT_ONE : '0;
        else
            line_nxt = (video_hsync & ~sat_line) ? line_cnt + CNT_ONE : line_cnt;
        en_nxt   = (video_enable & ~sat_en) ? en_base + CNT_ONE : en_base;
        act_nxt  = (video_enable & ~has_base & ~sat_act) ? act_base + CNT_ONE : act_base;

        h_act_cand = first_done ? first_h_act : (close_active ? line_en_cnt : '0);
        cand.h_total  = COORD_WIDTH_DEF'(last_clk);
        cand.v_total  = COORD_WIDTH_DEF'(line_cnt);
        cand.h_active = COORD_WIDTH_DEF'(h_act_cand);
        cand.v_active = COORD_WIDTH_DEF'(act_lines);
    end

    // Lock state machine: runaway line count wins, otherwise decisions happen at vsync.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        err       = 1'b0;
        if (ovf) begin
            state_nxt = SEARCH;
        end else if (video_vsync) begin
            case (state)
                SEARCH:  state_nxt = MEASURE;
                MEASURE: begin
                    latch     = 1'b1;
                    state_nxt = VERIFY;
                end
                VERIFY: begin
                    latch     = 1'b1;
                    state_nxt = ((cand == geom_q) && !frame_bad) ? LOCKED : VERIFY;
                end
                LOCKED: begin
                    if ((cand != geom_q) || frame_bad) begin
                        latch     = 1'b1;
                        err       = 1'b1;
                        state_nxt = VERIFY;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
        capture = video_vsync & (state != SEARCH);
    end

    // State register.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) state <= SEARCH;
        else          state <= state_nxt;
    end

    // Running line/frame counters and mismatch tracking, all cleared by vsync.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_in_line <= '0;
            line_cnt    <= '0;
            act_lines   <= '0;
            line_en_cnt <= '0;
            first_h_act <= '0;
            last_clk    <= '0;
            prev_clk    <= '0;
            line_has_en <= 1'b0;
            first_done  <= 1'b0;
            clk_ok      <= 1'b0;
            prev_ok     <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            clk_in_line <= clk_nxt;
            line_cnt    <= line_nxt;
            act_lines   <= act_nxt;
            line_en_cnt <= en_nxt;
            line_has_en <= video_enable | has_base;
            clk_ok      <= video_hsync | (~video_vsync & clk_ok);
            if (video_vsync) begin
                first_h_act <= '0;
                first_done  <= 1'b0;
                last_clk    <= '0;
                prev_clk    <= '0;
                prev_ok     <= 1'b0;
                mismatch    <= 1'b0;
            end else begin
                if (close_active & ~first_done) first_h_act <= line_en_cnt;
                first_done <= first_done | close_active;
                if (meas) begin
                    last_clk <= clk_in_line;
                    prev_clk <= clk_in_line;
                    prev_ok  <= 1'b1;
                end
                mismatch <= mismatch | act_len_bad | clk_bad | sat_now;
            end
        end
    end

    // Registered pixel path, latched geometry and status pulses.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x        <= '0;
            pixel_y        <= '0;
            pixel_rgb      <= '0;
            pixel_valid    <= 1'b0;
            geom_q         <= '0;
            checksum_valid <= 1'b0;
            locked         <= 1'b0;
            timing_error   <= 1'b0;
        end else begin
            pixel_rgb   <= video_rgb;
            pixel_valid <= video_enable;
            if (video_enable) begin
                pixel_x <= en_base;
                pixel_y <= has_base ? act_base - CNT_ONE : act_base;
            end
            if (latch) geom_q <= cand;
            checksum_valid <= capture;
            locked         <= (state_nxt == LOCKED);
            timing_error   <= err;
        end
    end

    assign h_total  = COORD_WIDTH'(geom_q.h_total);
    assign v_total  = COORD_WIDTH'(geom_q.v_total);
    assign h_active = COORD_WIDTH'(geom_q.h_active);
    assign v_active = COORD_WIDTH'(geom_q.v_active);

    video_checksum u_checksum (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .clear       (video_vsync),
        .enable      (video_enable),
        .data        (video_rgb),
        .capture     (capture),
        .checksum    (frame_checksum)
    );

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor using scaled-down frame geometries.
module tb_video_timing_monitor;

    localparam int CW = 12;

    logic          pixel_clock = 1'b0;
    logic          reset_n;
    logic [23:0]   video_rgb;
    logic          video_enable, video_vsync, video_hsync;
    logic [CW-1:0] pixel_x, pixel_y, h_total, v_total, h_active, v_active;
    logic [23:0]   pixel_rgb;
    logic          pixel_valid, checksum_valid, locked, timing_error;
    logic [31:0]   frame_checksum;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] macc = '0;
    logic [31:0] exp_cs = '0;
    bit          chk_xy = 1'b1;
    bit          prev_locked = 1'b0;
    bit          lock_at_vs = 1'b0;
    int          cv_cnt = 0, te_cnt = 0, vs_cnt = 0, lock_rise_vs = 0, cv0 = 0;

    video_timing_monitor #(.COORD_WIDTH(CW), .MAX_LINES(2047)) dut (
        .pixel_clock    (pixel_clock),
        .reset_n        (reset_n),
        .video_rgb      (video_rgb),
        .video_enable   (video_enable),
        .video_vsync    (video_vsync),
        .video_hsync    (video_hsync),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .pixel_rgb      (pixel_rgb),
        .pixel_valid    (pixel_valid),
        .h_total        (h_total),
        .v_total        (v_total),
        .h_active       (h_active),
        .v_active       (v_active),
        .frame_checksum (frame_checksum),
        .checksum_valid (checksum_valid),
        .locked         (locked),
        .timing_error   (timing_error)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pixel clock: drive inputs, step the checksum model, check outputs after the edge.
    task automatic drive_px(input bit vs, input bit hs, input bit en, input logic [23:0] rgb,
                            input int ex, input int ey);
        video_vsync  = vs;
        video_hsync  = hs;
        video_enable = en;
        video_rgb    = rgb;
        if (vs) begin
            exp_cs = macc;
            macc   = '0;
        end
        if (en) macc = {macc[30:0], macc[31]} ^ {8'h00, rgb};
        @(posedge pixel_clock);
        #1;
        chk("pixel_valid", 32'(pixel_valid), 32'(en));
        if (en) begin
            chk("pixel_rgb", 32'(pixel_rgb), 32'(rgb));
            if (chk_xy) begin
                chk("pixel_x", 32'(pixel_x), 32'(ex));
                chk("pixel_y", 32'(pixel_y), 32'(ey));
            end
        end
        if (checksum_valid) begin
            cv_cnt++;
            chk("frame_checksum", frame_checksum, exp_cs);
        end
        if (timing_error) te_cnt++;
        if (vs) begin
            vs_cnt++;
            lock_at_vs = locked;
        end
        if (locked && !prev_locked) lock_rise_vs = vs_cnt;
        prev_locked = locked;
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("rst_pixel_x", 32'(pixel_x), 32'd0);
        chk("rst_pixel_rgb", 32'(pixel_rgb), 32'd0);
        chk("rst_h_total", 32'(h_total), 32'd0);
        chk("rst_v_active", 32'(v_active), 32'd0);
        chk("rst_frame_checksum", frame_checksum, 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_checksum_valid", 32'(checksum_valid), 32'd0);
        @(posedge pixel_clock);
        #1;
        reset_n     = 1'b1;
        chk_xy      = 1'b0;
        prev_locked = 1'b0;
    endtask

    // One frame: vsync with hsync at its first clock, one hsync per line, rectangular active area.
    task automatic frame(input int ht, input int vt, input int ha, input int va, input int hst,
                         input int vst, input int str_line, input bit ones, input int rst_at);
        for (int l = 0; l < vt; l++) begin
            for (int c = 0; c < ht + ((l == str_line) ? 1 : 0); c++) begin
                logic [23:0] rgb;
                bit          en;
                if (l * ht + c == rst_at) mid_reset();
                en  = (l >= vst) && (l < vst + va) && (c >= hst) && (c < hst + ha);
                rgb = ones ? 24'h000001 : {8'(l), 8'(c), 8'(l * 7 + c)};
                drive_px(l == 0 && c == 0, c == 0, en, rgb, c - hst, l - vst);
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        video_rgb    = '0;
        video_enable = 1'b0;
        video_vsync  = 1'b0;
        video_hsync  = 1'b0;
        repeat (3) @(posedge pixel_clock);
        #1;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("reset_h_total", 32'(h_total), 32'd0);
        chk("reset_frame_checksum", frame_checksum, 32'd0);
        chk("reset_checksum_valid", 32'(checksum_valid), 32'd0);
        reset_n = 1'b1;
        repeat (3) drive_px(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);

        // 30x14 total, 24x10 active: lock at the third vsync
        cv_cnt = 0; vs_cnt = 0; lock_rise_vs = 0;
        repeat (2) frame(30, 14, 24, 10, 3, 2, -1, 1'b0, -1);
        chk("locked_before_3rd_vs", 32'(locked), 32'd0);
        chk("cv_after_2_vs", 32'(cv_cnt), 32'd1);
        frame(30, 14, 24, 10, 3, 2, -1, 1'b0, -1);
        chk("lock_rise_vsync", 32'(lock_rise_vs), 32'd3);
        chk("h_total", 32'(h_total), 32'd30);
        chk("v_total", 32'(v_total), 32'd14);
        chk("h_active", 32'(h_active), 32'd24);
        chk("v_active", 32'(v_active), 32'd10);
        frame(30, 14, 24, 10, 3, 2, -1, 1'b0, -1);
        chk("locked_steady", 32'(locked), 32'd1);
        chk("cv_after_4_vs", 32'(cv_cnt), 32'd3);

        // one stretched line while locked
        te_cnt = 0;
        frame(30, 14, 24, 10, 3, 2, 5, 1'b0, -1);
        chk("no_err_before_vs", 32'(te_cnt), 32'd0);
        frame(30, 14, 24, 10, 3, 2, -1, 1'b0, -1);
        chk("timing_error_pulses", 32'(te_cnt), 32'd1);
        chk("unlock_at_vs", 32'(lock_at_vs), 32'd0);
        frame(30, 14, 24, 10, 3, 2, -1, 1'b0, -1);
        chk("relock_at_vs", 32'(lock_at_vs), 32'd1);

        // runaway line count without vsync
        for (int l = 0; l < 2047; l++)
            for (int c = 0; c < 4; c++) drive_px(1'b0, c == 0, 1'b0, 24'h0, 0, 0);
        chk("ovf_locked", 32'(locked), 32'd0);
        chk("ovf_h_total_kept", 32'(h_total), 32'd30);
        cv_cnt = 0;
        frame(20, 8, 16, 5, 2, 1, -1, 1'b0, -1);
        chk("search_no_cv", 32'(cv_cnt), 32'd0);
        chk("measure_no_latch", 32'(h_total), 32'd30);
        frame(20, 8, 16, 5, 2, 1, -1, 1'b0, -1);
        chk("measure_cv", 32'(cv_cnt), 32'd1);
        chk("verify_h_total", 32'(h_total), 32'd20);
        chk("verify_v_total", 32'(v_total), 32'd8);
        chk("verify_h_active", 32'(h_active), 32'd16);
        chk("verify_v_active", 32'(v_active), 32'd5);
        chk("verify_unlocked", 32'(locked), 32'd0);
        frame(20, 8, 16, 5, 2, 1, -1, 1'b0, -1);
        chk("relock_after_search", 32'(lock_at_vs), 32'd1);

        // 2x2 active frame of ones: checksum 0xF
        reset_n = 1'b0;
        @(posedge pixel_clock);
        #1;
        reset_n = 1'b1;
        prev_locked = 1'b0;
        cv_cnt = 0;
        frame(6, 5, 2, 2, 1, 1, -1, 1'b1, -1);
        chk("cs_first_vs_no_cv", 32'(cv_cnt), 32'd0);
        frame(6, 5, 2, 2, 1, 1, -1, 1'b1, -1);
        chk("cs_cv_count_2", 32'(cv_cnt), 32'd1);
        chk("cs_value_2x2", frame_checksum, 32'h0000000F);
        frame(6, 5, 2, 2, 1, 1, -1, 1'b1, -1);
        chk("cs_cv_count_3", 32'(cv_cnt), 32'd2);
        chk("cs_value_again", frame_checksum, 32'h0000000F);

        // reset mid-frame
        frame(6, 5, 2, 2, 1, 1, -1, 1'b1, 15);
        chk_xy = 1'b1;
        cv0 = cv_cnt;
        frame(6, 5, 2, 2, 1, 1, -1, 1'b1, -1);
        chk("post_rst_vs1_no_cv", 32'(cv_cnt - cv0), 32'd0);
        frame(6, 5, 2, 2, 1, 1, -1, 1'b1, -1);
        chk("post_rst_vs2_cv", 32'(cv_cnt - cv0), 32'd1);
        chk("post_rst_checksum", frame_checksum, 32'h0000000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
